sdram_bus_arbiter: RTL and testbench

SDRAM_BUS_ARBITER -- requirements
Module: sdram_bus_arbiter

---
 rtl/sdram_bus_arbiter_if.sv | 36 +++
 rtl/sdram_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_sdram_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_bus_arbiter_if
//  Description : Bundle of the arbitration handshake between four bus masters
//                and the SDRAM bus arbiter.
//                  request            4  per-master bus request (bit i = master i)
//                  grant              4  one-hot bus grant, zero when bus is free
//                  beginTransactionIn 1  OR of all masters' beginTransaction
//                  endTransactionIn   1  OR of all masters' and slave's endTransaction
//                  busErrorOut        1  one-cycle bus error on watchdog expiry
//                  endTransactionOut  1  one-cycle forced end on watchdog expiry
//                  activeMaster       2  index of the last or current granted master
//                Modport master is the arbiter's view (it drives the grant side).
//                Modport slave is the requesters' view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdram_bus_arbiter_if;
   logic [3:0] request;
   logic [3:0] grant;
   logic       beginTransactionIn;
   logic       endTransactionIn;
   logic       busErrorOut;
   logic       endTransactionOut;
   logic [1:0] activeMaster;

   modport master (
      input  request, beginTransactionIn, endTransactionIn,
      output grant, busErrorOut, endTransactionOut, activeMaster
   );

   modport slave (
      output request, beginTransactionIn, endTransactionIn,
      input  grant, busErrorOut, endTransactionOut, activeMaster
   );
endinterface
`default_nettype wire

// File: rtl/sdram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_bus_arbiter
//  Description : Round-robin arbiter for four masters sharing one SDRAM bus,
//                with a begin watchdog (silent release) and a transaction
//                watchdog (bus error plus forced end-of-transaction).
//  Ports       : clock  - system clock, rising edge
//                reset  - asynchronous, active-high reset
//                bus    - sdram_bus_arbiter_if.master (request/grant handshake,
//                         begin/end strobes, error pulses, activeMaster)
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_bus_arbiter #(
   parameter int beginTimeout       = 16,
   parameter int transactionTimeout = 1024
) (
   input  wire                  clock,
   input  wire                  reset,
   sdram_bus_arbiter_if.master  bus
);

   localparam int CW = (transactionTimeout > 2) ? $clog2(transactionTimeout) : 1;
   localparam logic [CW-1:0] BEGIN_LAST = CW'(beginTimeout - 1);
   localparam logic [CW-1:0] TXN_LAST   = CW'(transactionTimeout - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANTED = 2'd1,
      ACTIVE  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [1:0]    pick;
   logic [1:0]    cand;
   logic          pick_valid;

   // Saturating increment: the counter never wraps back into range.
   assign count_next = (count == '1) ? count : count + CW'(1);

   // Round-robin search starting at activeMaster+1. Walking the offsets from
   // farthest to nearest lets the nearest requester overwrite the choice;
   // offset 4 wraps to the last owner itself, which thus has lowest priority.
   always_comb begin
      pick       = bus.activeMaster;
      pick_valid = 1'b0;
      cand       = bus.activeMaster;
      for (int k = 4; k >= 1; k--) begin
         cand = bus.activeMaster + 2'(k);
         if (bus.request[cand]) begin
            pick       = cand;
            pick_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state                 <= IDLE;
         count                 <= '0;
         bus.grant             <= 4'b0000;
         bus.busErrorOut       <= 1'b0;
         bus.endTransactionOut <= 1'b0;
         bus.activeMaster      <= 2'd3;
      end else begin
         // Error strobes are single-cycle by construction.
         bus.busErrorOut       <= 1'b0;
         bus.endTransactionOut <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  bus.grant        <= 4'b0001 << pick;
                  bus.activeMaster <= pick;
                  count            <= '0;
                  state            <= GRANTED;
               end
            end
            GRANTED: begin
               // A begin strobe wins over a request drop in the same cycle.
               if (bus.beginTransactionIn) begin
                  count <= '0;
                  state <= ACTIVE;
               end else if (!bus.request[bus.activeMaster] || count == BEGIN_LAST) begin
                  bus.grant <= 4'b0000;
                  count     <= '0;
                  state     <= RELEASE;
               end else begin
                  count <= count_next;
               end
            end
            ACTIVE: begin
               // A normal end in the expiry cycle suppresses the error pulses.
               if (bus.endTransactionIn) begin
                  bus.grant <= 4'b0000;
                  count     <= '0;
                  state     <= RELEASE;
               end else if (count == TXN_LAST) begin
                  bus.grant             <= 4'b0000;
                  bus.busErrorOut       <= 1'b1;
                  bus.endTransactionOut <= 1'b1;
                  count                 <= '0;
                  state                 <= RELEASE;
               end else begin
                  count <= count_next;
               end
            end
            RELEASE: begin
               // One idle bus-turnaround cycle before arbitration resumes.
               count <= '0;
               state <= IDLE;
            end
            default: begin
               bus.grant <= 4'b0000;
               count     <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_bus_arbiter
//  Description : Self-checking bench for sdram_bus_arbiter. A transaction-level
//                model tracks bus ownership and elapsed edges since grant or
//                begin; a negedge process compares every cycle, and directed
//                scenarios add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_bus_arbiter;

   localparam int BT = 16;
   localparam int TT = 1024;

   logic clock = 1'b0;
   logic reset = 1'b1;

   sdram_bus_arbiter_if bus ();

   sdram_bus_arbiter #(
      .beginTimeout      (BT),
      .transactionTimeout(TT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.master)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // ---------------- transaction-level model ----------------
   int         owner   = -1;   // master holding the bus, -1 when free
   bit         begun   = 1'b0; // owner has started its transaction
   bit         turn    = 1'b0; // bus in turnaround after a release
   int         last    = 3;    // last granted master
   longint     edge_no = 0;    // rising edges seen
   longint     mark    = 0;    // edge of grant or of begin
   logic [3:0] m_grant = 4'b0000;
   logic       m_err   = 1'b0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         owner = -1; begun = 1'b0; turn = 1'b0; last = 3;
         m_grant = 4'b0000; m_err = 1'b0;
      end else begin
         edge_no++;
         m_err = 1'b0;
         if (turn) begin
            turn = 1'b0;
         end else if (owner < 0) begin
            for (int k = 1; k <= 4; k++)
               if (owner < 0 && bus.request[(last + k) % 4]) owner = (last + k) % 4;
            if (owner >= 0) begin
               last = owner; begun = 1'b0; mark = edge_no;
            end
         end else if (!begun) begin
            if (bus.beginTransactionIn) begin
               begun = 1'b1; mark = edge_no;
            end else if (!bus.request[owner] || (edge_no - mark) == BT) begin
               owner = -1; turn = 1'b1;
            end
         end else begin
            if (bus.endTransactionIn) begin
               owner = -1; turn = 1'b1;
            end else if ((edge_no - mark) == TT) begin
               m_err = 1'b1; owner = -1; turn = 1'b1;
            end
         end
         m_grant = (owner < 0) ? 4'b0000 : 4'(1 << owner);
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         checks++;
         if (bus.grant !== m_grant || bus.busErrorOut !== m_err ||
             bus.endTransactionOut !== m_err || bus.activeMaster !== 2'(last)) begin
            errors++;
            $display("FAIL cycle_model t=%0t grant=%b/%b err=%b/%b endo=%b/%b am=%0d/%0d (got/want)",
                     $time, bus.grant, m_grant, bus.busErrorOut, m_err,
                     bus.endTransactionOut, m_err, bus.activeMaster, last);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_grant(output logic [3:0] g);
      int n = 0;
      while (bus.grant == 4'b0000 && n < 20) begin
         tick();
         n++;
      end
      g = bus.grant;
      check("grant_seen", 32'(g != 4'b0000), 32'd1);
   endtask

   task automatic pulse_begin();
      bus.beginTransactionIn = 1'b1;
      tick();
      bus.beginTransactionIn = 1'b0;
   endtask

   task automatic pulse_end();
      bus.endTransactionIn = 1'b1;
      tick();
      bus.endTransactionIn = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   logic [3:0] g;
   logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   int         n;

   initial begin
      bus.request = 4'b0000;
      bus.beginTransactionIn = 1'b0;
      bus.endTransactionIn   = 1'b0;
      reset = 1'b1;
      repeat (2) tick();
      check("reset_grant", 32'(bus.grant), 32'h0);
      check("reset_active_master", 32'(bus.activeMaster), 32'd3);
      check("reset_bus_error", 32'(bus.busErrorOut), 32'd0);
      reset = 1'b0;

      // Strobes with nobody on the bus are ignored.
      bus.beginTransactionIn = 1'b1;
      bus.endTransactionIn   = 1'b1;
      tick();
      bus.beginTransactionIn = 1'b0;
      bus.endTransactionIn   = 1'b0;
      repeat (2) tick();
      check("idle_strobes_ignored", 32'(bus.grant), 32'h0);

      // All masters requesting, three ACTIVE cycles each.
      bus.request = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_grant(g);
         check($sformatf("rr_order_%0d", i), 32'(g), 32'(rr_exp[i]));
         pulse_begin();
         repeat (2) tick();
         pulse_end();
         check($sformatf("rr_release_%0d", i), 32'(bus.grant), 32'h0);
      end
      bus.request = 4'b0000;
      repeat (3) tick();

      // Begin watchdog: grant held BT cycles, silent release, re-grant.
      bus.request = 4'b0100;
      wait_grant(g);
      check("begin_wd_grant", 32'(g), 32'h4);
      n = 1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.grant != 4'b0100) break;
         n++;
      end
      check("begin_wd_cycles", 32'(n), 32'(BT));
      check("begin_wd_no_error", 32'(bus.busErrorOut), 32'd0);
      wait_grant(g);
      check("begin_wd_regrant", 32'(g), 32'h4);
      bus.request = 4'b0000;
      tick();
      check("request_drop_release", 32'(bus.grant), 32'h0);
      repeat (3) tick();

      // Transaction watchdog fires TT edges after begin.
      bus.request = 4'b0010;
      wait_grant(g);
      check("txn_wd_grant", 32'(g), 32'h2);
      pulse_begin();
      n = 0;
      while (!bus.busErrorOut && n < TT + 50) begin
         tick();
         n++;
      end
      check("txn_wd_latency", 32'(n), 32'(TT));
      check("txn_wd_end_out", 32'(bus.endTransactionOut), 32'd1);
      check("txn_wd_grant_cleared", 32'(bus.grant), 32'h0);
      bus.request = 4'b0000;
      tick();
      check("txn_wd_pulse_width", 32'(bus.busErrorOut), 32'd0);
      repeat (3) tick();

      // End coincident with expiry: normal release, no pulses.
      bus.request = 4'b0001;
      wait_grant(g);
      check("coinc_grant", 32'(g), 32'h1);
      pulse_begin();
      bus.request = 4'b0000;
      repeat (TT - 1) tick();
      check("coinc_grant_held", 32'(bus.grant), 32'h1);
      pulse_end();
      check("coinc_no_error", 32'(bus.busErrorOut), 32'd0);
      check("coinc_no_end_out", 32'(bus.endTransactionOut), 32'd0);
      check("coinc_release", 32'(bus.grant), 32'h0);
      repeat (3) tick();

      // Request drop in the begin cycle: begin wins, grant held until end.
      bus.request = 4'b1000;
      wait_grant(g);
      check("drop_begin_grant", 32'(g), 32'h8);
      bus.request = 4'b0000;
      pulse_begin();
      repeat (4) tick();
      check("drop_begin_held", 32'(bus.grant), 32'h8);
      pulse_end();
      check("drop_begin_release", 32'(bus.grant), 32'h0);
      repeat (3) tick();

      // Reset in the middle of an ACTIVE transaction.
      bus.request = 4'b0010;
      wait_grant(g);
      check("reset_mid_grant", 32'(g), 32'h2);
      pulse_begin();
      tick();
      #2 reset = 1'b1;
      #1;
      check("async_reset_grant", 32'(bus.grant), 32'h0);
      check("async_reset_am", 32'(bus.activeMaster), 32'd3);
      check("async_reset_no_error", 32'(bus.busErrorOut), 32'd0);
      bus.request = 4'b0011;
      tick();
      reset = 1'b0;
      wait_grant(g);
      check("post_reset_first_grant", 32'(g), 32'h1);
      bus.request = 4'b0000;
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
